// File: rtl/ps2_scancode_decoder_if.sv
// Bus between the PS/2 receiver and console side and the scan-code decoder.
// Handshake: a scan byte is offered on the rising edge of scanCodeReady; charRead pops only while charValid=1.
interface ps2_scancode_decoder_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0]     scanCode;
  logic           scanCodeReady;
  logic           charRead;
  logic           overflowClear;
  logic [7:0]     charData;
  logic           charValid;
  logic           shiftHeld;
  logic           capsLock;
  logic           overflow;
  logic [1:0]     dbg_state;
  logic [PTR_W:0] dbg_count;

  modport master (
    output scanCode, scanCodeReady, charRead, overflowClear,
    input  charData, charValid, shiftHeld, capsLock, overflow, dbg_state, dbg_count
  );

  modport slave (
    input  scanCode, scanCodeReady, charRead, overflowClear,
    output charData, charValid, shiftHeld, capsLock, overflow, dbg_state, dbg_count
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set 2 scan-code to ASCII decoder with shift/caps tracking and a show-ahead character FIFO.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 8,
  localparam int PTR_W = $clog2(FIFO_DEPTH)
) (
  input logic                   clk,
  input logic                   rst,
  ps2_scancode_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam logic [PTR_W:0] FULL = FIFO_DEPTH[PTR_W:0];

  state_t           state;
  logic             l_shift;
  logic             r_shift;
  logic             caps_lock;
  logic             ready_prev;
  logic             overflow;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic       accept;
  logic [8:0] mapped;
  logic       push;
  logic       pop;
  logic       do_write;
  logic       drop;

  // Returns {hit, ascii}; shift and caps are the values before this byte.
  function automatic logic [8:0] map_code(input logic [7:0] code, input logic shifted,
                                          input logic caps);
    logic [4:0] idx;
    logic       is_letter;
    logic [8:0] r;
    idx       = '0;
    is_letter = 1'b1;
    r         = '0;
    case (code)
      8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;   8'h23: idx = 5'd3;
      8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;   8'h34: idx = 5'd6;   8'h33: idx = 5'd7;
      8'h43: idx = 5'd8;   8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
      8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;  8'h4D: idx = 5'd15;
      8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;  8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;
      8'h3C: idx = 5'd20;  8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
      8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
      default: is_letter = 1'b0;
    endcase
    if (is_letter) begin
      r = {1'b1, ((shifted ^ caps) ? 8'h41 : 8'h61) + {3'b000, idx}};
    end else begin
      case (code)
        8'h16:   r = {1'b1, shifted ? 8'h21 : 8'h31};
        8'h1E:   r = {1'b1, shifted ? 8'h40 : 8'h32};
        8'h26:   r = {1'b1, shifted ? 8'h23 : 8'h33};
        8'h25:   r = {1'b1, shifted ? 8'h24 : 8'h34};
        8'h2E:   r = {1'b1, shifted ? 8'h25 : 8'h35};
        8'h36:   r = {1'b1, shifted ? 8'h5E : 8'h36};
        8'h3D:   r = {1'b1, shifted ? 8'h26 : 8'h37};
        8'h3E:   r = {1'b1, shifted ? 8'h2A : 8'h38};
        8'h46:   r = {1'b1, shifted ? 8'h28 : 8'h39};
        8'h45:   r = {1'b1, shifted ? 8'h29 : 8'h30};
        8'h29:   r = {1'b1, 8'h20};
        8'h5A:   r = {1'b1, 8'h0D};
        8'h66:   r = {1'b1, 8'h08};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    accept   = bus.scanCodeReady & ~ready_prev;
    mapped   = map_code(bus.scanCode, l_shift | r_shift, caps_lock);
    push     = accept && (state == IDLE) && mapped[8];
    pop      = bus.charRead && (count != '0);
    do_write = push && ((count != FULL) || pop);
    drop     = push && (count == FULL) && !pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      l_shift    <= 1'b0;
      r_shift    <= 1'b0;
      caps_lock  <= 1'b0;
      ready_prev <= 1'b0;
    end else begin
      ready_prev <= bus.scanCodeReady;
      if (accept) begin
        case (state)
          IDLE: begin
            case (bus.scanCode)
              8'hF0:   state <= BRK;
              8'hE0:   state <= EXT;
              8'h12:   l_shift <= 1'b1;
              8'h59:   r_shift <= 1'b1;
              8'h58:   caps_lock <= ~caps_lock;
              default: state <= IDLE;
            endcase
          end
          BRK: begin
            if (bus.scanCode == 8'h12) l_shift <= 1'b0;
            if (bus.scanCode == 8'h59) r_shift <= 1'b0;
            state <= IDLE;
          end
          EXT:     state <= (bus.scanCode == 8'hF0) ? EXT_BRK : IDLE;
          EXT_BRK: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= mapped[7:0];
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)                   overflow <= 1'b1;
      else if (bus.overflowClear) overflow <= 1'b0;
    end
  end

  assign bus.charValid = (count != '0);
  assign bus.charData  = (count != '0) ? mem[rd_ptr] : 8'h00;
  assign bus.shiftHeld = l_shift | r_shift;
  assign bus.capsLock  = caps_lock;
  assign bus.overflow  = overflow;
  assign bus.dbg_state = state;
  assign bus.dbg_count = count;

endmodule
